// File: rtl/dmem_lsu.sv
// Single-port 32-bit data memory with byte/half/word load-store unit and one-cycle load latency.
// Define DMEM_MISALIGN_TRAP_EN to flag misaligned accesses instead of force-aligning them.
module dmem_lsu #(
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  stall,
  input  logic [2:0]            op_code,
  input  logic                  ld_unsigned,
  input  logic [ADDR_WIDTH+1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  rvalid,
  output logic                  err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [2:0] OP_LB = 3'd1;
  localparam logic [2:0] OP_LH = 3'd2;
  localparam logic [2:0] OP_LW = 3'd3;
  localparam logic [2:0] OP_SB = 3'd4;
  localparam logic [2:0] OP_SH = 3'd5;
  localparam logic [2:0] OP_SW = 3'd6;

  logic [31:0]           r_mem [DEPTH];
  logic [31:0]           r_rdata;
  logic                  r_rvalid;
  logic                  r_err;
  logic                  w_accept;
  logic                  w_is_load;
  logic                  w_is_store;
  logic                  w_misalign;
  logic                  w_wr_en;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [1:0]            w_lane;
  logic [3:0]            w_be;
  logic [31:0]           w_wlanes;
  logic [31:0]           w_word;
  logic [31:0]           w_ldata;

  // Lane select and sign/zero extension of a load result from the addressed word.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [2:0] op,
                                               input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[8*lane +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (op)
      OP_LB:   res = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      OP_LH:   res = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

`ifdef DMEM_MISALIGN_TRAP_EN
  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] lane);
    logic res;
    case (op)
      OP_LH, OP_SH: res = lane[0];
      OP_LW, OP_SW: res = (lane != 2'b00);
      default:      res = 1'b0;
    endcase
    return res;
  endfunction
`else
  function automatic logic [1:0] force_align(input logic [2:0] op, input logic [1:0] lane);
    logic [1:0] res;
    case (op)
      OP_LH, OP_SH: res = {lane[1], 1'b0};
      OP_LW, OP_SW: res = 2'b00;
      default:      res = lane;
    endcase
    return res;
  endfunction
`endif

  // Request decode, lane steering and write-enable generation.
  always_comb begin
    w_accept   = nrst & ~stall;
    w_idx      = addr[ADDR_WIDTH+1:2];
`ifdef DMEM_MISALIGN_TRAP_EN
    w_lane     = addr[1:0];
    w_misalign = is_misaligned(op_code, addr[1:0]);
`else
    w_lane     = force_align(op_code, addr[1:0]);
    w_misalign = 1'b0;
`endif
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_be       = 4'b0000;
    w_wlanes   = wdata;
    case (op_code)
      OP_LB, OP_LH, OP_LW: w_is_load = 1'b1;
      OP_SB: begin
        w_is_store = 1'b1;
        w_be       = 4'b0001 << w_lane;
        w_wlanes   = {4{wdata[7:0]}};
      end
      OP_SH: begin
        w_is_store = 1'b1;
        w_be       = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wlanes   = {2{wdata[15:0]}};
      end
      OP_SW: begin
        w_is_store = 1'b1;
        w_be       = 4'b1111;
      end
      default: w_is_load = 1'b0;
    endcase
    w_word  = r_mem[w_idx];
    w_ldata = w_misalign ? 32'h00000000 : load_extract(w_word, op_code, w_lane, ld_unsigned);
    w_wr_en = w_accept & w_is_store & ~w_misalign;
  end

  // Byte-lane memory write; contents are intentionally not cleared by reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_wr_en && w_be[i]) begin
        r_mem[w_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
      end
    end
  end

  // Registered load result and error flag, held while stalled.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_rdata  <= 32'h00000000;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
    end else if (!stall) begin
      r_err <= w_misalign;
      if (w_is_load) begin
        r_rdata  <= w_ldata;
        r_rvalid <= 1'b1;
      end else begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign rdata  = r_rdata;
  assign rvalid = r_rvalid;
  assign err    = r_err;

endmodule
